// File: rtl/aura_top_if.sv
// aura_top_if: memory bus between the attention engine and the memory system.
//   master (engine) : drives proc2mem_command/addr/data, receives the tags and load data.
//   slave  (memory) : the reverse direction.
// Command encoding: 2'd0 NONE, 2'd1 LOAD, 2'd2 STORE.
interface aura_top_if;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_transaction_tag;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_data_tag;

  modport master (
    output proc2mem_command,
    output proc2mem_addr,
    output proc2mem_data,
    input  mem2proc_transaction_tag,
    input  mem2proc_data,
    input  mem2proc_data_tag
  );

  modport slave (
    input  proc2mem_command,
    input  proc2mem_addr,
    input  proc2mem_data,
    output mem2proc_transaction_tag,
    output mem2proc_data,
    output mem2proc_data_tag
  );
endinterface

// File: rtl/aura_top.sv
// aura_top: hard-max attention engine. For every query row i it streams all K rows,
// finds j* = argmax_j dot(Q[i], K[j]) and copies V[j*] line by line into O[i].
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset; restarts from query row 0
//   mem  - aura_top_if.master memory bus (one outstanding transaction at a time)
//   done - high once every O row has been written; held until rst
// Build option: define AURA_ARGMAX_LAST_EN to make ties pick the highest K index
// (>= compare); by default ties pick the lowest K index (> compare).
module aura_top #(
  parameter int unsigned SEQ_LEN = 512,
  parameter int unsigned D_LINES = 8,
  parameter logic [31:0] Q_BASE  = 32'h0000_0000,
  parameter logic [31:0] K_BASE  = 32'h0000_8000,
  parameter logic [31:0] V_BASE  = 32'h0001_0000,
  parameter logic [31:0] O_BASE  = 32'h0001_8000
) (
  input  logic              clk,
  input  logic              rst,
  aura_top_if.master        mem,
  output logic              done
);

  localparam int unsigned IdxW     = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int unsigned LineW    = (D_LINES > 1) ? $clog2(D_LINES) : 1;
  localparam logic [31:0] RowBytes = 32'(8 * D_LINES);
  localparam logic [IdxW-1:0]  LastRow  = IdxW'(SEQ_LEN - 1);
  localparam logic [LineW-1:0] LastLine = LineW'(D_LINES - 1);

  localparam logic [1:0] MemNone  = 2'd0;
  localparam logic [1:0] MemLoad  = 2'd1;
  localparam logic [1:0] MemStore = 2'd2;

  localparam logic [2:0] StLoadQ  = 3'd0;
  localparam logic [2:0] StLoadK  = 3'd1;
  localparam logic [2:0] StCmp    = 3'd2;
  localparam logic [2:0] StCopyLd = 3'd3;
  localparam logic [2:0] StCopySt = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [IdxW-1:0]         i_q, i_d, j_q, j_d, idx_q, idx_d;
  logic [LineW-1:0]        l_q, l_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [31:0]             addr_q, addr_d;
  logic [63:0]             wdata_q, wdata_d;
  logic [3:0]              tag_q, tag_d;
  logic                    waiting_q, waiting_d;
  logic signed [31:0]      acc_q, acc_d, best_q, best_d;
  logic [D_LINES*64-1:0]   qbuf_q, qbuf_d;
  logic [63:0]             vline_q, vline_d;

  logic                    idle, accepted, load_accepted, returned, better;
  logic [63:0]             q_line;
  logic signed [31:0]      line_sum;

  function automatic logic [31:0] line_addr(input logic [31:0]      base,
                                            input logic [IdxW-1:0]  row,
                                            input logic [LineW-1:0] line);
    return base + 32'(row) * RowBytes + 32'(line) * 32'd8;
  endfunction

  // Idle: no command on the bus and no load waiting for its data.
  assign idle          = (cmd_q == MemNone) && !waiting_q;
  assign accepted      = (cmd_q != MemNone) && (mem.mem2proc_transaction_tag != 4'd0);
  assign load_accepted = accepted && (cmd_q == MemLoad);
  assign returned      = waiting_q && (mem.mem2proc_data_tag == tag_q);

`ifdef AURA_ARGMAX_LAST_EN
  assign better = (acc_q >= best_q);
`else
  assign better = (acc_q > best_q);
`endif

  // Eight signed int8 lane products of the current Q line against the returned K line.
  always_comb begin
    logic signed [7:0]  qa;
    logic signed [7:0]  kb;
    logic signed [31:0] prod;
    q_line   = qbuf_q[64*l_q +: 64];
    line_sum = '0;
    for (int k = 0; k < 8; k++) begin
      qa       = q_line[8*k +: 8];
      kb       = mem.mem2proc_data[8*k +: 8];
      prod     = 32'(qa) * 32'(kb);
      line_sum = line_sum + prod;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    l_d       = l_q;
    idx_d     = idx_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tag_d     = tag_q;
    waiting_d = waiting_q;
    acc_d     = acc_q;
    best_d    = best_q;
    qbuf_d    = qbuf_q;
    vline_d   = vline_q;

    if (load_accepted) begin
      cmd_d     = MemNone;
      tag_d     = mem.mem2proc_transaction_tag;
      waiting_d = 1'b1;
    end
    if (returned) begin
      waiting_d = 1'b0;
    end

    case (state_q)
      StLoadQ: begin
        if (idle) begin
          cmd_d  = MemLoad;
          addr_d = line_addr(Q_BASE, i_q, l_q);
        end
        if (returned) begin
          qbuf_d[64*l_q +: 64] = mem.mem2proc_data;
          if (l_q == LastLine) begin
            // Start of a query row: fresh search state.
            l_d     = '0;
            j_d     = '0;
            acc_d   = '0;
            best_d  = '0;
            idx_d   = '0;
            state_d = StLoadK;
          end else begin
            l_d = l_q + 1'b1;
          end
        end
      end
      StLoadK: begin
        if (idle) begin
          cmd_d  = MemLoad;
          addr_d = line_addr(K_BASE, j_q, l_q);
        end
        if (returned) begin
          acc_d = acc_q + line_sum;
          if (l_q == LastLine) begin
            l_d     = '0;
            state_d = StCmp;
          end else begin
            l_d = l_q + 1'b1;
          end
        end
      end
      StCmp: begin
        if ((j_q == '0) || better) begin
          best_d = acc_q;
          idx_d  = j_q;
        end
        acc_d = '0;
        if (j_q == LastRow) begin
          state_d = StCopyLd;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = StLoadK;
        end
      end
      StCopyLd: begin
        if (idle) begin
          cmd_d  = MemLoad;
          addr_d = line_addr(V_BASE, idx_q, l_q);
        end
        if (returned) begin
          vline_d = mem.mem2proc_data;
          state_d = StCopySt;
        end
      end
      StCopySt: begin
        if (idle) begin
          cmd_d   = MemStore;
          addr_d  = line_addr(O_BASE, i_q, l_q);
          wdata_d = vline_q;
        end
        // A store is finished as soon as memory accepts it.
        if (accepted && (cmd_q == MemStore)) begin
          cmd_d = MemNone;
          if (l_q == LastLine) begin
            l_d = '0;
            if (i_q == LastRow) begin
              state_d = StDone;
            end else begin
              i_d     = i_q + 1'b1;
              state_d = StLoadQ;
            end
          end else begin
            l_d     = l_q + 1'b1;
            state_d = StCopyLd;
          end
        end
      end
      StDone: begin
        cmd_d = MemNone;
      end
      default: begin
        state_d = StLoadQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoadQ;
      i_q       <= '0;
      j_q       <= '0;
      l_q       <= '0;
      idx_q     <= '0;
      cmd_q     <= MemNone;
      addr_q    <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      waiting_q <= 1'b0;
      acc_q     <= '0;
      best_q    <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      l_q       <= l_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      tag_q     <= tag_d;
      waiting_q <= waiting_d;
      acc_q     <= acc_d;
      best_q    <= best_d;
    end
  end

  // Pure datapath buffers; always written before being read after reset.
  always_ff @(posedge clk) begin
    qbuf_q  <= qbuf_d;
    vline_q <= vline_d;
  end

  assign mem.proc2mem_command = cmd_q;
  assign mem.proc2mem_addr    = addr_q;
  assign mem.proc2mem_data    = wdata_q;
  assign done                 = (state_q == StDone);

endmodule

// File: tb/tb_aura_top.sv
module tb_aura_top;
  localparam int SeqLen = 4;
  localparam int DLines = 8;
  localparam logic [31:0] QB = 32'h0000_0000;
  localparam logic [31:0] KB = 32'h0000_8000;
  localparam logic [31:0] VB = 32'h0001_0000;
  localparam logic [31:0] OB = 32'h0001_8000;
  localparam logic [1:0] CmdNone  = 2'd0;
  localparam logic [1:0] CmdLoad  = 2'd1;
  localparam logic [1:0] CmdStore = 2'd2;
  localparam logic [63:0] Ones  = 64'h0101_0101_0101_0101;
  localparam logic [63:0] Dead  = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int Budget = 20000;
`ifdef AURA_ARGMAX_LAST_EN
  localparam int TieIdx = SeqLen - 1;
`else
  localparam int TieIdx = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic done;

  aura_top_if bus ();

  aura_top #(
    .SEQ_LEN(SeqLen), .D_LINES(DLines),
    .Q_BASE(QB), .K_BASE(KB), .V_BASE(VB), .O_BASE(OB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (bus),
    .done(done)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [63:0] mem [0:16383];
  logic [3:0]  next_tag = 4'd1;
  int          wait_cnt = 0;
  bit          stall_en = 1'b0;
  bit          p1_valid, p2_valid;
  logic [3:0]  p1_tag, p2_tag;
  logic [13:0] p1_idx, p2_idx;
  int          store_cnt = 0;
  int          bad_store_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  assign bus.mem2proc_transaction_tag =
    ((bus.proc2mem_command != CmdNone) && (!stall_en || wait_cnt >= 3)) ? next_tag : 4'd0;

  // Each accepted load returns a wrong-tag decoy one cycle before the real data.
  always @(posedge clk) begin
    if (p2_valid) begin
      bus.mem2proc_data_tag <= p2_tag;
      bus.mem2proc_data     <= mem[p2_idx];
    end else if (p1_valid) begin
      bus.mem2proc_data_tag <= (p1_tag == 4'd15) ? 4'd1 : p1_tag + 4'd1;
      bus.mem2proc_data     <= ~mem[p1_idx];
    end else begin
      bus.mem2proc_data_tag <= 4'd0;
    end
    p2_valid <= p1_valid;
    p2_tag   <= p1_tag;
    p2_idx   <= p1_idx;
    p1_valid <= 1'b0;
    if (bus.mem2proc_transaction_tag != 4'd0) begin
      next_tag <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
      wait_cnt <= 0;
      if (bus.proc2mem_command == CmdLoad) begin
        p1_valid <= 1'b1;
        p1_tag   <= next_tag;
        p1_idx   <= bus.proc2mem_addr[16:3];
      end else if (bus.proc2mem_command == CmdStore) begin
        store_cnt = store_cnt + 1;
        if (bus.proc2mem_addr < OB || bus.proc2mem_addr >= OB + 32'(SeqLen * DLines * 8) ||
            bus.proc2mem_addr[2:0] != 3'd0)
          bad_store_cnt = bad_store_cnt + 1;
        mem[bus.proc2mem_addr[16:3]] = bus.proc2mem_data;
      end
    end else if (bus.proc2mem_command != CmdNone) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int li(input logic [31:0] base, input int row, input int line);
    return int'((base + 32'(row * DLines * 8 + line * 8)) >> 3);
  endfunction

  function automatic logic [63:0] vpat(input int row, input int line);
    return 64'hA5C3_0000_0000_0000 | 64'(row << 8) | 64'(line);
  endfunction

  task automatic fill_row(input logic [31:0] base, input int row, input logic [63:0] pat);
    for (int l = 0; l < DLines; l++) mem[li(base, row, l)] = pat;
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic prep_vo();
    for (int r = 0; r < SeqLen; r++) begin
      for (int l = 0; l < DLines; l++) begin
        mem[li(VB, r, l)] = vpat(r, l);
        mem[li(OB, r, l)] = Dead;
      end
    end
  endtask

  // Scores with all-ones Q: K0=64, K1=128, K2=0, K3=-64 -> K1 wins.
  task automatic load_basic();
    for (int r = 0; r < SeqLen; r++) fill_row(QB, r, Ones);
    fill_row(KB, 0, Ones);
    fill_row(KB, 1, 64'h0202_0202_0202_0202);
    fill_row(KB, 2, 64'h0);
    fill_row(KB, 3, 64'hFFFF_FFFF_FFFF_FFFF);
    prep_vo();
    fill_row(VB, 1, Ones);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < Budget; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int exp_idx(input int i);
    int best, s, idx;
    byte a, b;
    best = 0;
    idx  = 0;
    for (int j = 0; j < SeqLen; j++) begin
      s = 0;
      for (int l = 0; l < DLines; l++) begin
        for (int k = 0; k < 8; k++) begin
          a = mem[li(QB, i, l)][8*k +: 8];
          b = mem[li(KB, j, l)][8*k +: 8];
          s = s + int'(a) * int'(b);
        end
      end
`ifdef AURA_ARGMAX_LAST_EN
      if (j == 0 || s >= best) begin
`else
      if (j == 0 || s > best) begin
`endif
        best = s;
        idx  = j;
      end
    end
    return idx;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int r = 0; r < 2 * SeqLen; r++) fill_row(QB, r, 64'h0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.proc2mem_command !== CmdNone) begin
      n_fail++; $display("FAIL reset_cmd got %0d expected %0d", bus.proc2mem_command, CmdNone);
    end
    n_tests++;
    if (bus.proc2mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr got %h expected 0", bus.proc2mem_addr);
    end
    n_tests++;
    if (bus.proc2mem_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_data got %h expected 0", bus.proc2mem_data);
    end
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done got %b expected 0", done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus.proc2mem_command !== CmdLoad || bus.proc2mem_addr !== QB) begin
      n_fail++;
      $display("FAIL first_load got cmd %0d addr %h expected cmd %0d addr %h",
               bus.proc2mem_command, bus.proc2mem_addr, CmdLoad, QB);
    end
  endtask

  task automatic test_basic();
    bit ok;
    enter_reset();
    load_basic();
    rst = 1'b0;
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL basic_done got 0 expected 1");
    end
    for (int i = 0; i < SeqLen; i++) begin
      for (int l = 0; l < DLines; l++) begin
        n_tests++;
        if (mem[li(OB, i, l)] !== Ones) begin
          n_fail++;
          $display("FAIL basic_o[%0d][%0d] got %h expected %h", i, l, mem[li(OB, i, l)], Ones);
        end
      end
    end
  endtask

  task automatic test_ties();
    bit ok;
    enter_reset();
    for (int r = 0; r < SeqLen; r++) begin
      fill_row(QB, r, 64'h0504_0302_01FF_FEFD);
      fill_row(KB, r, 64'h0303_0303_0303_0303);
    end
    prep_vo();
    rst = 1'b0;
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL ties_done got 0 expected 1");
    end
    for (int i = 0; i < SeqLen; i++) begin
      for (int l = 0; l < DLines; l++) begin
        n_tests++;
        if (mem[li(OB, i, l)] !== vpat(TieIdx, l)) begin
          n_fail++;
          $display("FAIL ties_o[%0d][%0d] got %h expected %h", i, l, mem[li(OB, i, l)],
                   vpat(TieIdx, l));
        end
      end
    end
  endtask

  // Q=-128: K0=-128 -> +16384/lane, K1=+127 -> -16256/lane, K2=0, K3=+127.
  task automatic test_negative();
    bit ok;
    enter_reset();
    for (int r = 0; r < SeqLen; r++) fill_row(QB, r, 64'h8080_8080_8080_8080);
    fill_row(KB, 0, 64'h8080_8080_8080_8080);
    fill_row(KB, 1, 64'h7F7F_7F7F_7F7F_7F7F);
    fill_row(KB, 2, 64'h0);
    fill_row(KB, 3, 64'h7F7F_7F7F_7F7F_7F7F);
    prep_vo();
    rst = 1'b0;
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL neg_done got 0 expected 1");
    end
    for (int i = 0; i < SeqLen; i++) begin
      for (int l = 0; l < DLines; l++) begin
        n_tests++;
        if (mem[li(OB, i, l)] !== vpat(0, l)) begin
          n_fail++;
          $display("FAIL neg_o[%0d][%0d] got %h expected %h", i, l, mem[li(OB, i, l)],
                   vpat(0, l));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [1:0]  pc;
    logic [31:0] pa;
    logic [63:0] pd;
    bit          pend, ok;
    int          viol, stalls;
    pend = 1'b0; viol = 0; stalls = 0; ok = 1'b0;
    enter_reset();
    load_basic();
    stall_en = 1'b1;
    rst = 1'b0;
    for (int c = 0; c < Budget; c++) begin
      @(negedge clk);
      if (pend && (bus.proc2mem_command !== pc || bus.proc2mem_addr !== pa ||
                   bus.proc2mem_data !== pd)) viol++;
      pend = (bus.proc2mem_command != CmdNone) && (bus.mem2proc_transaction_tag == 4'd0);
      if (pend) stalls++;
      pc = bus.proc2mem_command;
      pa = bus.proc2mem_addr;
      pd = bus.proc2mem_data;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    stall_en = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL stall_done got 0 expected 1");
    end
    n_tests++;
    if (viol != 0) begin
      n_fail++; $display("FAIL stall_stable got %0d changes expected 0", viol);
    end
    n_tests++;
    if (stalls < 3) begin
      n_fail++; $display("FAIL stall_seen got %0d stalled cycles expected >= 3", stalls);
    end
    for (int i = 0; i < SeqLen; i++) begin
      for (int l = 0; l < DLines; l++) begin
        n_tests++;
        if (mem[li(OB, i, l)] !== Ones) begin
          n_fail++;
          $display("FAIL stall_o[%0d][%0d] got %h expected %h", i, l, mem[li(OB, i, l)], Ones);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    int snap;
    found = 1'b0;
    enter_reset();
    load_basic();
    rst = 1'b0;
    for (int c = 0; c < Budget; c++) begin
      @(negedge clk);
      if (bus.proc2mem_command == CmdStore && bus.proc2mem_addr >= OB + 32'(DLines * 8) &&
          bus.proc2mem_addr < OB + 32'(2 * DLines * 8)) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++; $display("FAIL midrst_reach got 0 expected 1 (row 1 store)");
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.proc2mem_command !== CmdNone) begin
      n_fail++; $display("FAIL midrst_cmd got %0d expected %0d", bus.proc2mem_command, CmdNone);
    end
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_done got %b expected 0", done);
    end
    snap = store_cnt;
    for (int r = 0; r < SeqLen; r++) fill_row(OB, r, Dead);
    repeat (2) @(negedge clk);
    n_tests++;
    if (store_cnt != snap) begin
      n_fail++; $display("FAIL midrst_nostore got %0d stores expected %0d", store_cnt, snap);
    end
    rst = 1'b0;
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL midrst_done_after got 0 expected 1");
    end
    for (int i = 0; i < SeqLen; i++) begin
      for (int l = 0; l < DLines; l++) begin
        n_tests++;
        if (mem[li(OB, i, l)] !== Ones) begin
          n_fail++;
          $display("FAIL midrst_o[%0d][%0d] got %h expected %h", i, l, mem[li(OB, i, l)], Ones);
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int e;
    enter_reset();
    for (int r = 0; r < SeqLen; r++) begin
      for (int l = 0; l < DLines; l++) begin
        mem[li(QB, r, l)] = {$urandom(), $urandom()};
        mem[li(KB, r, l)] = {$urandom(), $urandom()};
        mem[li(VB, r, l)] = {$urandom(), $urandom()};
        mem[li(OB, r, l)] = Dead;
      end
    end
    rst = 1'b0;
    wait_done(ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL rand_done got 0 expected 1");
    end
    for (int i = 0; i < SeqLen; i++) begin
      e = exp_idx(i);
      for (int l = 0; l < DLines; l++) begin
        n_tests++;
        if (mem[li(OB, i, l)] !== mem[li(VB, e, l)]) begin
          n_fail++;
          $display("FAIL rand_o[%0d][%0d] got %h expected %h (V%0d)", i, l, mem[li(OB, i, l)],
                   mem[li(VB, e, l)], e);
        end
      end
    end
    n_tests++;
    if (bad_store_cnt != 0) begin
      n_fail++; $display("FAIL store_region got %0d stray stores expected 0", bad_store_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_negative();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aura_top.md
AURA_TOP -- requirements
Module: aura_top

Interface
REQ-001 SHALL have parameter SEQ_LEN, default 512, meaning the number of Q, K, V and O rows (power of two, 2..512).
REQ-002 SHALL have parameter D_LINES, default 8, meaning the 64-bit lines per row (8 signed int8 lanes per line, 64 elements per row).
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 mem2proc_transaction_tag  in  MEM_TAG(4)  nonzero = current request accepted; combinational reply to the same-cycle command.
REQ-006 mem2proc_data  in  MEM_BLOCK(64)  load return data.
REQ-007 mem2proc_data_tag  in  MEM_TAG(4)  nonzero tag marking which accepted load mem2proc_data belongs to.
REQ-008 proc2mem_command  out  MEM_COMMAND  MEM_NONE, MEM_LOAD or MEM_STORE.
REQ-009 proc2mem_addr  out  ADDR(32)  byte address, 8-byte aligned.
REQ-010 proc2mem_data  out  MEM_BLOCK(64)  store data.
REQ-011 done  out  1  high when all output rows are written.

Function
REQ-012 SHALL compute hard-max attention: for each query row i, O[i] = V[j*], where j* = argmax over j of dot(Q[i], K[j]).
REQ-013 SHALL address row r, line l of a matrix at BASE + r*8*D_LINES + l*8, with BASE being Q_BASE, K_BASE, V_BASE or O_BASE from sys_defs.
REQ-014 SHALL treat lane k of a line as bits [8k+7:8k], interpreted as signed two's complement.
REQ-015 SHALL form dot products as signed 8x8 products summed into a 32-bit signed accumulator, with no saturation or overflow.
REQ-016 SHALL have at most one memory transaction outstanding; a command is held with a stable address and data until mem2proc_transaction_tag != 0 in the same cycle.
REQ-017 SHALL latch the accepted tag of a load and capture mem2proc_data only when mem2proc_data_tag equals the latched tag; a store is complete when it is accepted.
REQ-018 SHALL drive proc2mem_command = MEM_NONE whenever no request is pending.
REQ-019 FSM states and transitions:
- LOAD_Q: load Q[i], lines 0..D_LINES-1, into a row buffer.
- LOAD_K: stream K[j] line by line, accumulating 8 lane products per returned line.
- CMP: if j==0 or score > best, then best <= score and idx <= j; then j++. Go to LOAD_K if j < SEQ_LEN, else to COPY_LD.
- COPY_LD: load V[idx] line l.
- COPY_ST: store that line to O[i] line l; l++. After the last line, i++ and go to LOAD_Q, or to DONE after row SEQ_LEN-1.
- DONE: done=1, command NONE; stays in DONE until rst.
REQ-020 SHALL reset the accumulator at the start of each K row, and reset best/idx at the start of each query row.
REQ-021 SHALL begin LOAD_Q for row 0 the first cycle after rst deasserts; there is no start input.
REQ-022 SHALL ignore data returns whose tag does not match the latched tag.
REQ-023 SHALL never write outside the O region and never write the Q, K or V regions.

Reset
REQ-024 While rst is high: state=LOAD_Q, i=j=l=0, proc2mem_command=MEM_NONE, proc2mem_addr=0, proc2mem_data=0, done=0.
REQ-025 Reset asserted mid-operation SHALL abandon any outstanding transaction and restart from row 0 without issuing a further store.

Configuration
REQ-026 SHALL support macro AURA_ARGMAX_LAST_EN.
- Defined: CMP updates when score >= best, so ties select the highest j.
- Undefined: only a strictly greater score updates, so ties select the lowest j.

Verification
REQ-027 SEQ_LEN=2, Q[0]=Q[1]=all 1, K[0]=all 1, K[1]=all 2, V[1]=0x0101..01 -> O[0] and O[1] equal V[1] on every line; done=1.
REQ-028 SEQ_LEN=4, all K rows identical -> O rows equal V[0] without the macro, and equal V[3] with AURA_ARGMAX_LAST_EN.
REQ-029 Negative lanes: Q lane = 0x80 (-128), K[0] = 0x80, K[1] = 0x7F -> K[0] wins (+16384 per lane vs -16256 per lane); O = V[0].
REQ-030 Memory that returns tag 0 for 3 cycles before accepting -> command and address stay stable throughout, and the final result is unchanged.
REQ-031 Assert rst during COPY_ST of row 1 -> command goes to MEM_NONE the next cycle and done=0; after release the run completes with correct O.
REQ-032 SEQ_LEN=512 with random Q/K/V -> O matches a software golden model line by line; no store to an address outside the O region.
